pattern_check: RTL and testbench

Receive-side checker for bus and pipe testing. Consumes a stream of data words (for example, words written by the host over a pipe) and regenerates the expected pattern locally from the same mode and seed. It compares every accepted word against the expected word and reports word count, saturating error count, a sticky error flag and completion. It sits directly downstream of the pipe endpoint FIFO, in the same test path as the transmit-side pattern generator.

---
 rtl/pattern_pkg.sv | 19 +
 rtl/pattern_expect.sv | 72 +++++++
 rtl/pattern_check.sv | 150 +++++++++++++++
 tb/tb_pattern_check.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern checker: mode encodings, LFSR taps and seed,
// and the checker state enum.
package pattern_pkg;

  localparam logic [2:0] MODE_COUNTER  = 3'b000;
  localparam logic [2:0] MODE_LFSR     = 3'b001;
  localparam logic [2:0] MODE_WALK1    = 3'b010;
  localparam logic [2:0] MODE_WALK0    = 3'b011;
  localparam logic [2:0] MODE_HAMMER   = 3'b100;
  localparam logic [2:0] MODE_NEIGHBOR = 3'b101;

  localparam int unsigned LFSR_TAP_HI  = 31;
  localparam int unsigned LFSR_TAP_MID = 21;
  localparam int unsigned LFSR_TAP_LO  = 1;
  localparam logic [31:0] LFSR_SEED    = 32'h04030201;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/pattern_expect.sv
// Expected-word generator: reloads on load (latching mode), steps once per advance.
module pattern_expect
  import pattern_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] LFSR_RESET = LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [2:0]       mode,
  input  logic             advance,
  output logic [WIDTH-1:0] expected
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             toggle_q, toggle_d;

  always_comb begin
    mode_d   = mode_q;
    exp_d    = exp_q;
    nb_d     = nb_q;
    toggle_d = toggle_q;
    if (load) begin
      mode_d   = mode;
      toggle_d = 1'b1;
      nb_d     = ~One;
      case (mode)
        MODE_COUNTER: exp_d = One;
        MODE_LFSR:    exp_d = WIDTH'(LFSR_RESET);
        MODE_WALK1:   exp_d = One;
        MODE_WALK0:   exp_d = ~One;
        default:      exp_d = '0;
      endcase
    end else if (advance) begin
      toggle_d = ~toggle_q;
      // Neighbor pattern only moves its hole on the all-zero half of each pair.
      if (!toggle_q) nb_d = {nb_q[WIDTH-2:0], nb_q[WIDTH-1]};
      case (mode_q)
        MODE_COUNTER:  exp_d = exp_q + One;
        MODE_LFSR:     exp_d = {exp_q[WIDTH-2:0],
                                exp_q[LFSR_TAP_HI] ^ exp_q[LFSR_TAP_MID] ^ exp_q[LFSR_TAP_LO]};
        MODE_WALK1,
        MODE_WALK0:    exp_d = {exp_q[WIDTH-2:0], exp_q[WIDTH-1]};
        MODE_HAMMER:   exp_d = {WIDTH{toggle_q}};
        MODE_NEIGHBOR: exp_d = toggle_q ? nb_q : '0;
        default:       exp_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_COUNTER;
      exp_q    <= '0;
      nb_q     <= '0;
      toggle_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      exp_q    <= exp_d;
      nb_q     <= nb_d;
      toggle_q <= toggle_d;
    end
  end

  assign expected = exp_q;

endmodule

// File: rtl/pattern_check.sv
// Receive-side pattern checker with a two-stage registered compare.
// First-mismatch capture is built only when PATTERN_CHECK_FIRST_ERR_EN is defined.
module pattern_check
  import pattern_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] LFSR_RESET = LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [31:0]      length,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      word_count,
  output logic [31:0]      error_count,
  output logic             error,
  output logic [31:0]      first_err_index,
  output logic [WIDTH-1:0] first_err_expected,
  output logic [WIDTH-1:0] first_err_actual
);

  state_e           state_q, state_d;
  logic [31:0]      length_q, word_count_q, error_count_q;
  logic             error_q;
  logic             s1_valid_q, s2_mis_q;
  logic [WIDTH-1:0] s1_din_q, s1_exp_q;
  logic [WIDTH-1:0] expected;
  logic             accept, last;

  assign accept = (state_q == RUN) && din_valid && !start;
  assign last   = accept && (length_q != '0) && (word_count_q + 32'd1 == length_q);

  pattern_expect #(
    .WIDTH      (WIDTH),
    .LFSR_RESET (LFSR_RESET)
  ) u_expect (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .mode     (mode),
    .advance  (accept),
    .expected (expected)
  );

  always_comb begin
    state_d = state_q;
    busy    = (state_q == RUN) || (state_q == DRAIN);
    done    = (state_q == DONE);
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (last) state_d = DRAIN;
        DRAIN:   if (!s1_valid_q) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      length_q      <= '0;
      word_count_q  <= '0;
      error_count_q <= '0;
      error_q       <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_din_q      <= '0;
      s1_exp_q      <= '0;
      s2_mis_q      <= 1'b0;
    end else if (start) begin
      // Words still in flight belong to the previous run and are dropped.
      length_q      <= length;
      word_count_q  <= '0;
      error_count_q <= '0;
      error_q       <= 1'b0;
      s1_valid_q    <= 1'b0;
      s2_mis_q      <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_din_q     <= din;
        s1_exp_q     <= expected;
        word_count_q <= word_count_q + 32'd1;
      end
      s2_mis_q <= s1_valid_q && (s1_din_q != s1_exp_q);
      if (s2_mis_q) begin
        error_q <= 1'b1;
        if (error_count_q != '1) error_count_q <= error_count_q + 32'd1;
      end
    end
  end

  assign word_count  = word_count_q;
  assign error_count = error_count_q;
  assign error       = error_q;

`ifdef PATTERN_CHECK_FIRST_ERR_EN
  logic [31:0]      s1_idx_q, s2_idx_q, fe_idx_q;
  logic [WIDTH-1:0] s2_exp_q, s2_act_q, fe_exp_q, fe_act_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_idx_q <= '0;
      s2_idx_q <= '0;
      s2_exp_q <= '0;
      s2_act_q <= '0;
      fe_idx_q <= '0;
      fe_exp_q <= '0;
      fe_act_q <= '0;
    end else if (start) begin
      fe_idx_q <= '0;
      fe_exp_q <= '0;
      fe_act_q <= '0;
    end else begin
      if (accept) s1_idx_q <= word_count_q;
      if (s1_valid_q) begin
        s2_idx_q <= s1_idx_q;
        s2_exp_q <= s1_exp_q;
        s2_act_q <= s1_din_q;
      end
      if (s2_mis_q && !error_q) begin
        fe_idx_q <= s2_idx_q;
        fe_exp_q <= s2_exp_q;
        fe_act_q <= s2_act_q;
      end
    end
  end

  assign first_err_index    = fe_idx_q;
  assign first_err_expected = fe_exp_q;
  assign first_err_actual   = fe_act_q;
`else
  assign first_err_index    = '0;
  assign first_err_expected = '0;
  assign first_err_actual   = '0;
`endif

endmodule

// File: tb/tb_pattern_check.sv
// Self-checking bench for pattern_check: per-word error results go through a scoreboard
// queue and are compared when the two-stage pipeline delivers them.
module tb_pattern_check;
  import pattern_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, din_valid;
  logic [2:0]  mode;
  logic [31:0] length, din;
  logic        busy, done, error;
  logic [31:0] word_count, error_count, first_err_index, first_err_expected, first_err_actual;

  pattern_check dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .mode               (mode),
    .length             (length),
    .din                (din),
    .din_valid          (din_valid),
    .busy               (busy),
    .done               (done),
    .word_count         (word_count),
    .error_count        (error_count),
    .error              (error),
    .first_err_index    (first_err_index),
    .first_err_expected (first_err_expected),
    .first_err_actual   (first_err_actual)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [31:0] err_cnt;
    logic        err;
  } sb_t;
  sb_t sb_q[$];

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] m_lfsr;
  logic [31:0] m_err;
  int          m_n;

  // Closed-form expected sequences; only the LFSR is stepped iteratively.
  function automatic logic [31:0] model_word(input logic [2:0] m, input int n,
                                             input logic [31:0] lfsr);
    case (m)
      MODE_COUNTER:  return 32'(n + 1);
      MODE_LFSR:     return lfsr;
      MODE_WALK1:    return 32'd1 << (n % 32);
      MODE_WALK0:    return ~(32'd1 << (n % 32));
      MODE_HAMMER:   return (n % 2 == 1) ? 32'hFFFFFFFF : 32'h0;
      MODE_NEIGHBOR: return (n % 2 == 0) ? 32'h0 : ~(32'd1 << ((n / 2) % 32));
      default:       return 32'h0;
    endcase
  endfunction

  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      n_checks++;
      if (error_count !== e.err_cnt || error !== e.err)
        $display("FAIL sb_error @cyc %0d: got cnt=%0d err=%0b want cnt=%0d err=%0b",
                 cyc, error_count, error, e.err_cnt, e.err);
      else n_pass++;
    end
  endtask

  task automatic do_start(input logic [2:0] m, input logic [31:0] len, input bit dv);
    sb_q.delete();
    din_valid = dv;
    din       = 32'h1;
    start     = 1'b1;
    mode      = m;
    length    = len;
    step();
    start     = 1'b0;
    din_valid = 1'b0;
    m_lfsr    = LFSR_SEED;
    m_err     = '0;
    m_n       = 0;
  endtask

  task automatic feed(input logic [2:0] m, input int n, input int bad_idx,
                      input logic [31:0] bad_val, input bit zeros, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      sb_t e;
      if (gaps && $urandom_range(3) == 0) begin
        din_valid = 1'b0;
        step();
      end
      w = model_word(m, m_n, m_lfsr);
      din = zeros ? 32'h0 : ((m_n == bad_idx) ? bad_val : w);
      if (din !== w) m_err++;
      din_valid = 1'b1;
      e.due = cyc + 3;
      e.err_cnt = m_err;
      e.err = (m_err != 0);
      sb_q.push_back(e);
      step();
      m_n++;
      m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1]};
    end
    din_valid = 1'b0;
  endtask

  task automatic flush(input string name);
    repeat (3) step();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL %s_flush: got %0d pending want 0", name, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din_valid = 1'b0; mode = '0; length = '0; din = '0;
    step(); step();
    n_checks++;
    if ({busy, done, error} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {busy, done, error});
    else n_pass++;
    n_checks++;
    if ({word_count, error_count, first_err_index, first_err_expected, first_err_actual} !== '0)
      $display("FAIL reset_counts: got wc=%0d ec=%0d fe=%h/%h/%h want all 0", word_count,
               error_count, first_err_index, first_err_expected, first_err_actual);
    else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_counter();
    do_start(MODE_COUNTER, 8, 1'b0);
    feed(MODE_COUNTER, 8, -1, 0, 1'b0, 1'b0);
    n_checks++;
    if ({busy, done} !== 2'b10) $display("FAIL cnt_drain0: got busy,done=%b want 10", {busy, done});
    else n_pass++;
    din_valid = 1'b1;  // beyond length, must be ignored
    din = 32'h9;
    step();
    n_checks++;
    if (done !== 1'b0) $display("FAIL cnt_drain1: got done=%b want 0", done);
    else n_pass++;
    step();
    n_checks++;
    if ({busy, done} !== 2'b01) $display("FAIL cnt_done: got busy,done=%b want 01", {busy, done});
    else n_pass++;
    step();
    din_valid = 1'b0;
    n_checks++;
    if (word_count !== 32'd8) $display("FAIL cnt_words: got %0d want 8", word_count);
    else n_pass++;
    n_checks++;
    if (error_count !== 32'd0 || error !== 1'b0)
      $display("FAIL cnt_errors: got %0d/%b want 0/0", error_count, error);
    else n_pass++;
    flush("cnt");
  endtask

  task automatic test_lfsr();
    do_start(MODE_LFSR, 0, 1'b0);
    feed(MODE_LFSR, 1000, -1, 0, 1'b0, 1'b1);
    flush("lfsr");
    n_checks++;
    if (word_count !== 32'd1000 || error_count !== 32'd0 || busy !== 1'b1)
      $display("FAIL lfsr_end: got wc=%0d ec=%0d busy=%b want 1000/0/1",
               word_count, error_count, busy);
    else n_pass++;
  endtask

  task automatic test_first_err();
    logic [95:0] want;
    do_start(MODE_COUNTER, 16, 1'b0);
    feed(MODE_COUNTER, 16, 5, 32'hDEADBEEF, 1'b0, 1'b0);
    flush("ferr");
    n_checks++;
    if (error_count !== 32'd1 || error !== 1'b1 || done !== 1'b1)
      $display("FAIL ferr_count: got ec=%0d err=%b done=%b want 1/1/1", error_count, error, done);
    else n_pass++;
`ifdef PATTERN_CHECK_FIRST_ERR_EN
    want = {32'd5, 32'd6, 32'hDEADBEEF};
`else
    want = '0;
`endif
    n_checks++;
    if ({first_err_index, first_err_expected, first_err_actual} !== want)
      $display("FAIL ferr_capture: got %h want %h",
               {first_err_index, first_err_expected, first_err_actual}, want);
    else n_pass++;
  endtask

  task automatic test_neighbor_restart();
    do_start(MODE_NEIGHBOR, 8, 1'b0);
    n_checks++;
    if ({busy, done, error} !== 3'b100 || word_count !== 0 || error_count !== 0)
      $display("FAIL restart_clear: got busy,done,err=%b wc=%0d ec=%0d want 100/0/0",
               {busy, done, error}, word_count, error_count);
    else n_pass++;
    feed(MODE_NEIGHBOR, 8, -1, 0, 1'b0, 1'b0);
    flush("nb");
    n_checks++;
    if (error_count !== 0 || done !== 1'b1)
      $display("FAIL nb_end: got ec=%0d done=%b want 0/1", error_count, done);
    else n_pass++;
  endtask

  task automatic test_hammer_walk();
    do_start(MODE_HAMMER, 4, 1'b0);
    feed(MODE_HAMMER, 4, -1, 0, 1'b1, 1'b0);
    flush("ham");
    n_checks++;
    if (error_count !== 32'd2) $display("FAIL ham_errors: got %0d want 2", error_count);
    else n_pass++;
    do_start(MODE_WALK1, 40, 1'b0);
    feed(MODE_WALK1, 40, -1, 0, 1'b0, 1'b0);
    flush("walk1");
    do_start(MODE_WALK0, 40, 1'b0);
    feed(MODE_WALK0, 40, 33, 32'h0, 1'b0, 1'b0);
    flush("walk0");
    n_checks++;
    if (error_count !== 32'd1 || word_count !== 32'd40)
      $display("FAIL walk0_end: got ec=%0d wc=%0d want 1/40", error_count, word_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_start(MODE_COUNTER, 0, 1'b0);
    feed(MODE_COUNTER, 3, 1, 32'h0, 1'b0, 1'b0);
    do_start(MODE_COUNTER, 0, 1'b1);  // start wins over the coincident word
    n_checks++;
    if (word_count !== 32'd0) $display("FAIL b2b_start_word: got wc=%0d want 0", word_count);
    else n_pass++;
    feed(MODE_COUNTER, 2, -1, 0, 1'b0, 1'b0);
    flush("b2b");
    n_checks++;
    if (word_count !== 32'd2 || error_count !== 0 || error !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_end: got wc=%0d ec=%0d err=%b busy=%b want 2/0/0/1",
               word_count, error_count, error, busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_start(MODE_COUNTER, 0, 1'b0);
    feed(MODE_COUNTER, 4, 1, 32'h0, 1'b0, 1'b0);
    din_valid = 1'b1;
    din = 32'h5;
    step();
    n_checks++;
    if (error !== 1'b1 || word_count !== 32'd5)
      $display("FAIL ar_pre: got err=%b wc=%0d want 1/5", error, word_count);
    else n_pass++;
    #2;
    sb_q.delete();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, error, word_count, error_count} !== '0)
      $display("FAIL ar_clear: got busy=%b done=%b err=%b wc=%0d ec=%0d want all 0",
               busy, done, error, word_count, error_count);
    else n_pass++;
    step();
    n_checks++;
    if ({busy, word_count, first_err_index, first_err_actual} !== '0)
      $display("FAIL ar_hold: got busy=%b wc=%0d fe=%h/%h want 0", busy, word_count,
               first_err_index, first_err_actual);
    else n_pass++;
    din_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_counter();
    test_lfsr();
    test_first_err();
    test_neighbor_restart();
    test_hammer_walk();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
